// File: rtl/uart_bram_loader.sv
// uart_bram_loader: receives a program image over an 8N1 UART and writes it
// as 16-bit words into BRAM port A, holding the CPU while a packet is in flight.
// Packet: 0xA5, LEN_HI, LEN_LO, LEN x {DATA_HI, DATA_LO}, CHK (XOR of LEN/DATA bytes).
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   uart_rx         serial input (idle high, LSB first), asynchronous to clk
//   bram_wea        one-cycle write strobe to BRAM port A
//   bram_addra      16-bit write address
//   bram_dina       16-bit write data
//   cpu_hold        high while a packet is being received
//   load_done       level, packet loaded and checksum matched
//   load_err        level, framing / checksum / timeout error
module uart_bram_loader #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        bram_wea,
  output logic [15:0] bram_addra,
  output logic [15:0] bram_dina,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TIMEOUT_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TO_W         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    P_IDLE, P_LEN_HI, P_LEN_LO, P_DATA_HI, P_DATA_LO, P_CHECK, P_DONE, P_ERROR
  } pk_state_t;

  // ---------------- UART receiver ----------------
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_rx_state, w_rx_state;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt;
  logic [2:0]       r_rx_bits, w_rx_bits;
  logic [7:0]       r_rx_shift, w_rx_shift;
  logic             r_byte_valid, w_byte_valid;
  logic             r_frame_err, w_frame_err;

  // Receiver state and datapath registers; synchronizer resets to line idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bits    <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta    <= uart_rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_rx_state   <= w_rx_state;
      r_rx_cnt     <= w_rx_cnt;
      r_rx_bits    <= w_rx_bits;
      r_rx_shift   <= w_rx_shift;
      r_byte_valid <= w_byte_valid;
      r_frame_err  <= w_frame_err;
    end
  end

  // Receiver next state: start bit confirmed at half-bit, data/stop at bit centres.
  always_comb begin
    w_rx_state   = r_rx_state;
    w_rx_cnt     = r_rx_cnt + CNT_W'(1);
    w_rx_bits    = r_rx_bits;
    w_rx_shift   = r_rx_shift;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt = '0;
        // require a real high->low edge so a held-low line never restarts
        if (r_rx_prev && !r_rx_sync) w_rx_state = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == CNT_W'(HALF_BIT - 1)) begin
          w_rx_cnt   = '0;
          w_rx_bits  = '0;
          w_rx_state = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_rx_cnt   = '0;
          w_rx_shift = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_bits  = r_rx_bits + 3'd1;
          if (r_rx_bits == 3'd7) w_rx_state = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_rx_cnt     = '0;
          w_byte_valid = r_rx_sync;
          w_frame_err  = !r_rx_sync;
          w_rx_state   = RX_IDLE;
        end
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  // ---------------- packet loader ----------------
  pk_state_t       r_state, w_state;
  logic [15:0]     r_len, w_len;
  logic [7:0]      r_hi, w_hi;
  logic [7:0]      r_chk, w_chk;
  logic [15:0]     r_addr, w_addr;
  logic            r_wea, w_wea;
  logic [15:0]     r_dina, w_dina;
  logic            r_hold, w_hold;
  logic            r_done, w_done;
  logic            r_err, w_err;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_active, w_timeout;

  assign w_active  = (r_state != P_IDLE) && (r_state != P_DONE) && (r_state != P_ERROR);
  assign w_timeout = w_active && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Inter-byte idle timer: runs only while a packet is open and the line is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_to_cnt <= '0;
    else if (!w_active || r_rx_state != RX_IDLE) r_to_cnt <= '0;
    else if (!w_timeout)                        r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  // Loader state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= P_IDLE;
      r_len   <= '0;
      r_hi    <= '0;
      r_chk   <= '0;
      r_addr  <= BASE_ADDR;
      r_wea   <= 1'b0;
      r_dina  <= '0;
      r_hold  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_len   <= w_len;
      r_hi    <= w_hi;
      r_chk   <= w_chk;
      r_addr  <= w_addr;
      r_wea   <= w_wea;
      r_dina  <= w_dina;
      r_hold  <= w_hold;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  // Loader next state; address advances the cycle after each write strobe.
  always_comb begin
    w_state = r_state;
    w_len   = r_len;
    w_hi    = r_hi;
    w_chk   = r_chk;
    w_addr  = r_wea ? r_addr + 16'd1 : r_addr;
    w_wea   = 1'b0;
    w_dina  = r_dina;
    w_hold  = r_hold;
    w_done  = r_done;
    w_err   = r_err;
    case (r_state)
      P_IDLE, P_DONE, P_ERROR: begin
        if (r_byte_valid && r_rx_shift == SYNC_BYTE) begin
          w_state = P_LEN_HI;
          w_hold  = 1'b1;
          w_done  = 1'b0;
          w_err   = 1'b0;
          w_addr  = BASE_ADDR;
          w_chk   = '0;
        end
      end
      P_LEN_HI: begin
        if (r_byte_valid) begin
          w_len[15:8] = r_rx_shift;
          w_chk       = r_chk ^ r_rx_shift;
          w_state     = P_LEN_LO;
        end
      end
      P_LEN_LO: begin
        if (r_byte_valid) begin
          w_len[7:0] = r_rx_shift;
          w_chk      = r_chk ^ r_rx_shift;
          w_state    = ({r_len[15:8], r_rx_shift} == 16'd0) ? P_CHECK : P_DATA_HI;
        end
      end
      P_DATA_HI: begin
        if (r_byte_valid) begin
          w_hi    = r_rx_shift;
          w_chk   = r_chk ^ r_rx_shift;
          w_state = P_DATA_LO;
        end
      end
      P_DATA_LO: begin
        if (r_byte_valid) begin
          w_wea   = 1'b1;
          w_dina  = {r_hi, r_rx_shift};
          w_chk   = r_chk ^ r_rx_shift;
          w_len   = r_len - 16'd1;
          w_state = (r_len == 16'd1) ? P_CHECK : P_DATA_HI;
        end
      end
      P_CHECK: begin
        if (r_byte_valid) begin
          w_hold = 1'b0;
          if (r_rx_shift == r_chk) begin
            w_state = P_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = P_ERROR;
            w_err   = 1'b1;
          end
        end
      end
      default: w_state = P_IDLE;
    endcase
    // framing error or inter-byte timeout aborts an open packet
    if (w_active && (r_frame_err || w_timeout)) begin
      w_state = P_ERROR;
      w_err   = 1'b1;
      w_done  = 1'b0;
      w_hold  = 1'b0;
      w_wea   = 1'b0;
    end
  end

  assign bram_wea   = r_wea;
  assign bram_addra = r_addr;
  assign bram_dina  = r_dina;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule

// File: tb/tb_uart_bram_loader.sv
// Self-checking bench for uart_bram_loader: directed packets plus randomized
// packets checked against a packet-level reference model.
module tb_uart_bram_loader;

  localparam int unsigned CLK_FREQ     = 100_000_000;
  localparam int unsigned BAUD         = 3_125_000;
  localparam int unsigned CPB          = CLK_FREQ / BAUD;
  localparam int unsigned TIMEOUT_BITS = 64;
  localparam int unsigned TIMEOUT_CYC  = TIMEOUT_BITS * CPB;
  // base near the top of memory so longer packets exercise address wrap
  localparam logic [15:0] TB_BASE      = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        bram_wea;
  logic [15:0] bram_addra;
  logic [15:0] bram_dina;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  uart_bram_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .BASE_ADDR(TB_BASE), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] obs[$];    // observed writes {addr, data}
  logic [31:0] exp_w[$];  // expected writes {addr, data}
  logic [7:0]  pkt[$];
  logic        exp_done, exp_err;

  // record every write strobe cycle
  always @(negedge clk) if (bram_wea) obs.push_back({bram_addra, bram_dina});

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int unsigned cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int unsigned gap_bits);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop;
    idle(CPB);
    uart_rx = 1'b1;
    idle(gap_bits * CPB + 1);
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i], 1'b1, $urandom_range(0, 2));
  endtask

  // append checksum (XOR of everything after the sync byte), optionally corrupted
  task automatic append_chk(input bit good);
    logic [7:0] c;
    int s;
    s = 0;
    while (pkt[s] != 8'hA5) s++;
    c = 8'h00;
    for (int i = s + 1; i < pkt.size(); i++) c ^= pkt[i];
    if (!good) c ^= 8'($urandom_range(1, 255));
    pkt.push_back(c);
  endtask

  // Reference: parse a complete packet, list expected writes and final status.
  task automatic model_pkt();
    int          s;
    int          len;
    logic [7:0]  c;
    logic [15:0] d;
    s = 0;
    while (pkt[s] != 8'hA5) s++;
    len = {pkt[s+1], pkt[s+2]};
    c = pkt[s+1] ^ pkt[s+2];
    exp_w.delete();
    for (int w = 0; w < len; w++) begin
      d = {pkt[s+3+2*w], pkt[s+4+2*w]};
      c ^= d[15:8] ^ d[7:0];
      exp_w.push_back({16'(TB_BASE + 16'(w)), d});
    end
    exp_done = (pkt[s+3+2*len] == c);
    exp_err  = !exp_done;
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done, input logic err);
    check({tag, "_hold"}, 32'(cpu_hold), 32'(hold));
    check({tag, "_done"}, 32'(load_done), 32'(done));
    check({tag, "_err"},  32'(load_err), 32'(err));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(obs.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs.size(); i++)
      check({tag, "_wr"}, obs[i], exp_w[i]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned len;
    bit          good;
    int          waited;

    rst = 1'b1;
    uart_rx = 1'b1;
    idle(3);
    check("rst_wea",  32'(bram_wea), 32'd0);
    check("rst_addr", 32'(bram_addra), 32'(TB_BASE));
    check("rst_dina", 32'(bram_dina), 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(4);

    // directed: two-word packet with good checksum
    obs.delete();
    pkt = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    append_chk(1'b1);
    model_pkt();
    send_byte(pkt[0], 1'b1, 0);
    check("t1_hold_after_sync", 32'(cpu_hold), 32'd1);
    for (int i = 1; i < pkt.size(); i++) send_byte(pkt[i], 1'b1, 0);
    idle(4);
    check_writes("t1");
    check_status("t1", 1'b0, exp_done, exp_err);

    // same data, bad checksum
    obs.delete();
    pkt = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
    model_pkt();
    send_pkt();
    idle(4);
    check_writes("t2");
    check_status("t2", 1'b0, 1'b0, 1'b1);

    // leading garbage, then empty packet
    obs.delete();
    pkt = '{8'h55, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    model_pkt();
    send_pkt();
    idle(4);
    check_writes("t3");
    check_status("t3", 1'b0, 1'b1, 1'b0);

    // short low glitch on an idle line
    obs.delete();
    uart_rx = 1'b0;
    #100ns;
    uart_rx = 1'b1;
    idle(20 * CPB);
    check("t6_nwr", 32'(obs.size()), 32'd0);
    check_status("t6", 1'b0, 1'b1, 1'b0);

    // framing error while DONE is ignored
    send_byte(8'h33, 1'b0, 1);
    check_status("fe_idle", 1'b0, 1'b1, 1'b0);

    // truncated packet, then silence past the timeout
    obs.delete();
    pkt = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_pkt();
    idle(TIMEOUT_CYC - 3 * CPB);
    check_status("t4_pre", 1'b1, 1'b0, 1'b0);
    waited = 0;
    while (!load_err && waited < int'(6 * CPB)) begin
      idle(1);
      waited++;
    end
    check_status("t4", 1'b0, 1'b0, 1'b1);
    check("t4_nwr", 32'(obs.size()), 32'd0);

    // framing error on LEN_LO
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h02, 1'b0, 1);
    check_status("t5_fe", 1'b0, 1'b0, 1'b1);

    // reset in the middle of DATA_HI of a second packet
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'(i & 1);
      idle(CPB);
    end
    rst = 1'b1;
    uart_rx = 1'b1;
    idle(1);
    check("t5_rst_wea",  32'(bram_wea), 32'd0);
    check("t5_rst_addr", 32'(bram_addra), 32'(TB_BASE));
    check_status("t5_rst", 1'b0, 1'b0, 1'b0);
    obs.delete();
    idle(2);
    rst = 1'b0;
    idle(30 * CPB);
    check("t5_nwr", 32'(obs.size()), 32'd0);
    check_status("t5_post", 1'b0, 1'b0, 1'b0);

    // randomized packets
    for (int k = 0; k < 10; k++) begin
      obs.delete();
      pkt.delete();
      if ($urandom_range(0, 2) == 0) pkt.push_back(8'($urandom_range(0, 8'hA4)));
      len  = (k == 0) ? 3 : $urandom_range(0, 4);
      good = (k < 2) || ($urandom_range(0, 3) != 0);
      pkt.push_back(8'hA5);
      pkt.push_back(8'h00);
      pkt.push_back(8'(len));
      for (int unsigned j = 0; j < 2 * len; j++)
        pkt.push_back((k == 1 && j == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
      append_chk(good);
      model_pkt();
      send_pkt();
      idle(4);
      check_writes("rnd");
      check_status("rnd", 1'b0, exp_done, exp_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
